// File: rtl/vic_irq_responder.sv
// CPU-side end of the VIC interrupt handshake: captures a source id into a single
// pending slot, requests the core with the handler vector, and holds o_busy until return.
module vic_irq_responder #(
    parameter int                NUM_IRQ         = 31,
    parameter int                ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE        = ADDR_W'(32'h0000_0100),
    parameter int                VEC_STRIDE_LOG2 = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_irq,
    input  logic [4:0]        i_irq_addr,
    input  logic              i_core_en,
    input  logic              i_ack,
    input  logic              i_reti,
    output logic              o_busy,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_vector,
    output logic [4:0]        o_irq_id,
    output logic              o_pending,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE,
        RELEASE
    } state_t;

    localparam logic [5:0] NUM_IRQ_L = 6'(NUM_IRQ);

    state_t     state;
    logic       slot_valid;
    logic [4:0] slot_id;
    logic       id_ok;
    logic       consume;

    assign id_ok     = {1'b0, i_irq_addr} < NUM_IRQ_L;
    assign consume   = (state == IDLE) && slot_valid && i_core_en;
    assign o_pending = slot_valid;

    // Pending slot: a strobe may refill it in the same cycle the FSM drains it;
    // otherwise an occupied slot keeps the older id and flags an overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_valid <= 1'b0;
            slot_id    <= '0;
            o_err      <= 1'b0;
        end else begin
            if (i_irq && !id_ok) begin
                o_err <= 1'b1;
            end
            if (i_irq && id_ok) begin
                if (!slot_valid || consume) begin
                    slot_valid <= 1'b1;
                    slot_id    <= i_irq_addr;
                end else begin
                    o_err <= 1'b1;
                end
            end else if (consume) begin
                slot_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_req    <= 1'b0;
            o_vector <= '0;
            o_irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (consume) begin
                        state    <= REQ;
                        o_irq_id <= slot_id;
                        o_vector <= VEC_BASE + (ADDR_W'(slot_id) << VEC_STRIDE_LOG2);
                        o_req    <= 1'b1;
                        o_busy   <= 1'b1;
                    end
                end
                REQ: begin
                    if (i_ack) begin
                        state <= SERVICE;
                        o_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (i_reti) begin
                        state  <= RELEASE;
                        o_busy <= 1'b0;
                    end
                end
                // One guaranteed low cycle on o_busy so the VIC always sees a falling edge.
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vic_irq_responder.sv
// Self-checking bench for vic_irq_responder: a scoreboard queue of expected (id, vector)
// pairs is popped whenever o_req rises, alongside direct handshake checks.
module tb_vic_irq_responder;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_irq;
    logic [4:0]  i_irq_addr;
    logic        i_core_en;
    logic        i_ack;
    logic        i_reti;
    logic        o_busy, o_req, o_pending, o_err;
    logic [31:0] o_vector;
    logic [4:0]  o_irq_id;
    logic        w_busy, w_req, w_pending, w_err;
    logic [31:0] w_vector;
    logic [4:0]  w_irq_id;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    logic req_prev = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 i_clk = ~i_clk;

    vic_irq_responder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_irq(i_irq), .i_irq_addr(i_irq_addr),
        .i_core_en(i_core_en), .i_ack(i_ack), .i_reti(i_reti),
        .o_busy(o_busy), .o_req(o_req), .o_vector(o_vector), .o_irq_id(o_irq_id),
        .o_pending(o_pending), .o_err(o_err)
    );

    // Second instance with a base near the top of the address space to exercise wrap.
    vic_irq_responder #(.VEC_BASE(32'hFFFF_FFF0)) dut_wrap (
        .i_clk(i_clk), .i_rst(i_rst), .i_irq(i_irq), .i_irq_addr(i_irq_addr),
        .i_core_en(i_core_en), .i_ack(i_ack), .i_reti(i_reti),
        .o_busy(w_busy), .o_req(w_req), .o_vector(w_vector), .o_irq_id(w_irq_id),
        .o_pending(w_pending), .o_err(w_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic irq, input logic [4:0] addr,
                                 input logic en, input logic ack, input logic reti);
        i_rst      = rst;
        i_irq      = irq;
        i_irq_addr = addr;
        i_core_en  = en;
        i_ack      = ack;
        i_reti     = reti;
        @(posedge i_clk);
        #1;
        i_rst  = 1'b0;
        i_irq  = 1'b0;
        i_ack  = 1'b0;
        i_reti = 1'b0;
    endtask

    task automatic pushExpected(input logic [4:0] id, input logic [31:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    // Scoreboard consumer: every new request must match the oldest expected entry.
    always @(negedge i_clk) begin
        if (o_req === 1'b1 && req_prev === 1'b0) begin
            checkOutput("sb_req_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                checkOutput("sb_id", 32'(o_irq_id), 32'(exp_e.id));
                checkOutput("sb_vector", o_vector, exp_e.vec);
            end
        end
        req_prev = o_req;
    end

    initial begin
        i_rst = 1'b1; i_irq = 1'b0; i_irq_addr = '0; i_core_en = 1'b1;
        i_ack = 1'b0; i_reti = 1'b0;
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_req", 32'(o_req), 0);
        checkOutput("rst_pending", 32'(o_pending), 0);
        checkOutput("rst_err", 32'(o_err), 0);
        checkOutput("rst_vector", o_vector, 0);
        checkOutput("rst_id", 32'(o_irq_id), 0);

        // Test 1: basic handshake with id 5
        pushExpected(5'd5, 32'h114);
        applyStimulus(0, 1, 5, 1, 0, 0);
        checkOutput("t1_pending", 32'(o_pending), 1);
        checkOutput("t1_req_early", 32'(o_req), 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t1_req", 32'(o_req), 1);
        checkOutput("t1_busy", 32'(o_busy), 1);
        checkOutput("t1_vector", o_vector, 32'h114);
        checkOutput("t1_pending_cleared", 32'(o_pending), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_req_held_en_low", 32'(o_req), 1);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("t1_ack_req", 32'(o_req), 0);
        checkOutput("t1_ack_busy", 32'(o_busy), 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("t1_release_busy", 32'(o_busy), 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t1_idle_busy", 32'(o_busy), 0);
        checkOutput("t1_idle_req", 32'(o_req), 0);

        // Test 2: capture held while core interrupts are disabled
        pushExpected(5'd3, 32'h10C);
        applyStimulus(0, 1, 3, 0, 0, 0);
        checkOutput("t2_pending", 32'(o_pending), 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2_req_disabled", 32'(o_req), 0);
        checkOutput("t2_pending_kept", 32'(o_pending), 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t2_req", 32'(o_req), 1);
        checkOutput("t2_vector", o_vector, 32'h10C);
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);

        // Test 3: pending capture during service, overrun, back-to-back request
        pushExpected(5'd2, 32'h108);
        pushExpected(5'd7, 32'h11C);
        applyStimulus(0, 1, 2, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("t3_service_id", 32'(o_irq_id), 2);
        applyStimulus(0, 1, 7, 1, 0, 0);
        checkOutput("t3_pending7", 32'(o_pending), 1);
        checkOutput("t3_no_err_yet", 32'(o_err), 0);
        applyStimulus(0, 1, 9, 1, 0, 0);
        checkOutput("t3_overrun_err", 32'(o_err), 1);
        checkOutput("t3_still_pending", 32'(o_pending), 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("t3_release_busy", 32'(o_busy), 0);
        checkOutput("t3_release_req", 32'(o_req), 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t3_idle_req", 32'(o_req), 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t3_b2b_req", 32'(o_req), 1);
        checkOutput("t3_b2b_id", 32'(o_irq_id), 7);
        checkOutput("t3_b2b_vector", o_vector, 32'h11C);
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);

        // Test 4: invalid id after a reset clears the sticky error
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("t4_err_cleared", 32'(o_err), 0);
        applyStimulus(0, 1, 31, 1, 0, 0);
        checkOutput("t4_err", 32'(o_err), 1);
        checkOutput("t4_no_pending", 32'(o_pending), 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t4_no_req", 32'(o_req), 0);
        checkOutput("t4_no_busy", 32'(o_busy), 0);

        // Test 5: reset in REQ while a strobe arrives, then stray ack/reti in IDLE
        applyStimulus(1, 0, 0, 1, 0, 0);
        pushExpected(5'd6, 32'h118);
        applyStimulus(0, 1, 6, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t5_req", 32'(o_req), 1);
        applyStimulus(1, 1, 8, 1, 0, 0);
        checkOutput("t5_rst_req", 32'(o_req), 0);
        checkOutput("t5_rst_busy", 32'(o_busy), 0);
        checkOutput("t5_rst_pending", 32'(o_pending), 0);
        checkOutput("t5_rst_vector", o_vector, 0);
        checkOutput("t5_rst_id", 32'(o_irq_id), 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t5_slot_empty_req", 32'(o_req), 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("t5_stray_ack_busy", 32'(o_busy), 0);
        checkOutput("t5_stray_ack_req", 32'(o_req), 0);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("t5_stray_reti_busy", 32'(o_busy), 0);
        checkOutput("t5_stray_err", 32'(o_err), 0);

        // Test 6: vector wrap on the high-base instance, reti alongside ack ignored
        pushExpected(5'd4, 32'h110);
        applyStimulus(0, 1, 4, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t6_wrap_req", 32'(w_req), 1);
        checkOutput("t6_wrap_vector", w_vector, 32'h0000_0000);
        applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("t6_ack_reti_busy", 32'(o_busy), 1);
        checkOutput("t6_ack_reti_req", 32'(o_req), 0);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("t6_release_busy", 32'(o_busy), 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);

        checkOutput("sb_queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
